// File: rtl/hs_ram_arbiter.sv
// Hiscore/CPU single-port RAM arbiter with a guard-gap handover FSM.
// Optional watchdog on the hand-over wait: define HS_ARB_TIMEOUT_EN.
module hs_ram_arbiter #(
   parameter int ADDR_W = 16,
   parameter int GUARD  = 4
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_din,
   input  logic              cpu_we,
   input  logic              cpu_mreq,
   input  logic              hs_req,
   input  logic [ADDR_W-1:0] hs_addr,
   input  logic [7:0]        hs_din,
   input  logic              hs_we,
   input  logic              hs_strobe,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_din,
   output logic              ram_we,
   input  logic [7:0]        ram_dout,
   output logic              pause_cpu,
   output logic              hs_grant,
   output logic [7:0]        hs_dout,
   output logic              hs_ack
`ifdef HS_ARB_TIMEOUT_EN
   ,
   output logic              hs_timeout
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HOLD,
      S_GUARD,
      S_GRANT,
      S_DRAIN
   } state_t;

   localparam logic [3:0] GUARD_LD = 4'(GUARD - 1);

   state_t     state;
   state_t     state_nx;
   logic [3:0] cnt;
   logic [3:0] cnt_nx;
   logic [1:0] sync;
   logic       run;
   logic       wd_fire;
   logic       waiting;

   // Reset is applied asynchronously but released through two flops.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         sync <= 2'b00;
      end else begin
         sync <= {sync[0], 1'b1};
      end
   end

   assign run     = sync[1];
   assign waiting = (state == S_HOLD) || (state == S_GUARD);

`ifdef HS_ARB_TIMEOUT_EN
   logic [15:0] wd;

   assign wd_fire = waiting && (wd == 16'hFFFE);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         wd         <= 16'h0000;
         hs_timeout <= 1'b0;
      end else if (!run) begin
         wd         <= 16'h0000;
         hs_timeout <= 1'b0;
      end else begin
         wd         <= waiting ? wd + 16'd1 : 16'h0000;
         hs_timeout <= wd_fire;
      end
   end
`else
   assign wd_fire = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
         S_IDLE: begin
            if (hs_req) state_nx = S_HOLD;
         end
         S_HOLD: begin
            if (!hs_req || wd_fire) begin
               state_nx = S_DRAIN;
            end else if (!cpu_mreq) begin
               cnt_nx   = GUARD_LD;
               state_nx = S_GUARD;
            end
         end
         S_GUARD: begin
            if (!hs_req || wd_fire) begin
               state_nx = S_DRAIN;
            end else if (cpu_mreq) begin
               state_nx = S_HOLD;
            end else if (cnt == 4'd0) begin
               state_nx = S_GRANT;
            end else begin
               cnt_nx = cnt - 4'd1;
            end
         end
         S_GRANT: begin
            if (!hs_req) state_nx = S_DRAIN;
         end
         S_DRAIN: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Grant drops with hs_req so the port is never driven by a leaving owner.
   assign pause_cpu = (state != S_IDLE);
   assign hs_grant  = (state == S_GRANT) && hs_req;
   assign ram_addr  = hs_grant ? hs_addr : cpu_addr;
   assign ram_din   = hs_grant ? hs_din : cpu_din;
   assign ram_we    = hs_grant ? (hs_we & hs_strobe) : cpu_we;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         cnt     <= 4'd0;
         hs_ack  <= 1'b0;
         hs_dout <= 8'h00;
      end else if (!run) begin
         state   <= S_IDLE;
         cnt     <= 4'd0;
         hs_ack  <= 1'b0;
         hs_dout <= 8'h00;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         hs_ack <= hs_grant & hs_strobe;
         // Read data lands on ram_dout in the ack cycle; hold it afterwards.
         if (hs_ack) hs_dout <= ram_dout;
      end
   end

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// Randomized scoreboard bench for hs_ram_arbiter against a phase-level model.
// Covers handover timing, hiscore accesses, release, async reset, watchdog.
module tb_hs_ram_arbiter;

   localparam int AW = 16;
   localparam int GD = 4;

   logic          clk_sys = 1'b0;
   logic          reset_n = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [7:0]    cpu_din = '0;
   logic          cpu_we = 1'b0;
   logic          cpu_mreq = 1'b0;
   logic          hs_req = 1'b0;
   logic [AW-1:0] hs_addr = '0;
   logic [7:0]    hs_din = '0;
   logic          hs_we = 1'b0;
   logic          hs_strobe = 1'b0;
   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_din;
   logic          ram_we;
   logic [7:0]    ram_dout = '0;
   logic          pause_cpu;
   logic          hs_grant;
   logic [7:0]    hs_dout;
   logic          hs_ack;
`ifdef HS_ARB_TIMEOUT_EN
   logic          hs_timeout;
`endif

   always #5 clk_sys = ~clk_sys;

   hs_ram_arbiter #(.ADDR_W(AW), .GUARD(GD)) dut (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .cpu_addr  (cpu_addr),
      .cpu_din   (cpu_din),
      .cpu_we    (cpu_we),
      .cpu_mreq  (cpu_mreq),
      .hs_req    (hs_req),
      .hs_addr   (hs_addr),
      .hs_din    (hs_din),
      .hs_we     (hs_we),
      .hs_strobe (hs_strobe),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_we    (ram_we),
      .ram_dout  (ram_dout),
      .pause_cpu (pause_cpu),
      .hs_grant  (hs_grant),
      .hs_dout   (hs_dout),
`ifdef HS_ARB_TIMEOUT_EN
      .hs_timeout(hs_timeout),
`endif
      .hs_ack    (hs_ack)
   );

   // Single-port RAM with registered read, read-before-write.
   logic [7:0] mem [0:65535];
   logic [7:0] shadow [0:65535];

   always @(posedge clk_sys) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   typedef enum int {M_IDLE, M_PRE, M_GRANT, M_DRAIN} mphase_t;

   typedef struct {
      int         due;
      bit         rd;
      logic [7:0] data;
   } ack_t;

   ack_t    q[$];
   mphase_t ph = M_IDLE;
   int      idle_run = 0;
   int      skip = 2;
   int      cyc = 0;
   int      n_cmp = 0;
   int      n_bad = 0;
   bit      dout_pend = 0;
   logic [7:0]    dout_exp = '0;
   logic          exp_pause = 0;
   logic          exp_grant = 0;
   logic [AW-1:0] exp_addr = '0;
   logic [7:0]    exp_din = '0;
   logic          exp_we = 0;
`ifdef HS_ARB_TIMEOUT_EN
   int   pre_cycles = 0;
   logic to_pend = 0;
   logic exp_to = 0;
`endif

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] want);
      n_cmp++;
      if (act !== want) begin
         n_bad++;
         $display("FAIL %s cyc=%0d: got %0h want %0h", nm, cyc, act, want);
      end
   endtask

   // Expected outputs for the current cycle from the model phase.
   task automatic eval_cycle();
      exp_pause = (ph != M_IDLE);
      exp_grant = (ph == M_GRANT) && hs_req;
      exp_addr  = exp_grant ? hs_addr : cpu_addr;
      exp_din   = exp_grant ? hs_din : cpu_din;
      exp_we    = exp_grant ? (hs_we & hs_strobe) : cpu_we;
`ifdef HS_ARB_TIMEOUT_EN
      exp_to    = to_pend;
`endif
      if (exp_grant && hs_strobe)
         q.push_back('{cyc + 1, !hs_we, shadow[hs_addr]});
      if (exp_we) shadow[exp_addr] = exp_din;
   endtask

   task automatic advance();
`ifdef HS_ARB_TIMEOUT_EN
      logic to_next = 0;
`endif
      if (!reset_n) begin
         ph = M_IDLE;
         skip = 2;
         q.delete();
         dout_pend = 0;
      end else if (skip > 0) begin
         skip--;
         ph = M_IDLE;
      end else begin
         case (ph)
            M_IDLE: if (hs_req) begin
               ph = M_PRE;
               idle_run = 0;
`ifdef HS_ARB_TIMEOUT_EN
               pre_cycles = 0;
`endif
            end
            M_PRE: begin
               idle_run = cpu_mreq ? 0 : idle_run + 1;
               if (!hs_req) ph = M_DRAIN;
               else if (idle_run == GD + 1) ph = M_GRANT;
`ifdef HS_ARB_TIMEOUT_EN
               pre_cycles++;
               if (pre_cycles == 65535) begin
                  ph = M_DRAIN;
                  to_next = 1;
               end
`endif
            end
            M_GRANT: if (!hs_req) ph = M_DRAIN;
            default: ph = M_IDLE;
         endcase
      end
      @(posedge clk_sys);
      #1;
`ifdef HS_ARB_TIMEOUT_EN
      to_pend = to_next;
`endif
      cyc++;
   endtask

   task automatic step();
      eval_cycle();
      advance();
   endtask

   always @(negedge clk_sys) begin
      bit   exp_ack;
      ack_t e;
      chk("pause_cpu", pause_cpu, exp_pause);
      chk("hs_grant", hs_grant, exp_grant);
      chk("ram_addr", ram_addr, exp_addr);
      chk("ram_din", ram_din, exp_din);
      chk("ram_we", ram_we, exp_we);
`ifdef HS_ARB_TIMEOUT_EN
      chk("hs_timeout", hs_timeout, exp_to);
`endif
      if (dout_pend) begin
         chk("hs_dout", hs_dout, dout_exp);
         dout_pend = 0;
      end
      while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
      exp_ack = (q.size() > 0) && (q[0].due == cyc);
      chk("hs_ack", hs_ack, exp_ack);
      if (exp_ack) begin
         e = q.pop_front();
         if (e.rd) begin
            dout_pend = 1;
            dout_exp  = e.data;
         end
      end
   end

   task automatic do_reset();
      reset_n = 1'b0;
      q.delete();
      dout_pend = 0;
      ph = M_IDLE;
      step();
      chk("rst hs_dout", hs_dout, 8'h00);
      chk("rst hs_ack", hs_ack, 1'b0);
      step();
      reset_n = 1'b1;
      repeat (3) step();
   endtask

   task automatic wait_grant(output int k);
      k = 0;
      while (!hs_grant && k < 30) begin
         step();
         k++;
      end
   endtask

   task automatic reset_mid();
      hs_we = 1'b1;
      hs_strobe = 1'b1;
      hs_addr = 16'h1234;
      hs_din = 8'h5A;
      cpu_we = 1'b0;
      #1;
      chk("pre-reset ram_we", ram_we, 1'b1);
      reset_n = 1'b0;
      q.delete();
      dout_pend = 0;
      ph = M_IDLE;
`ifdef HS_ARB_TIMEOUT_EN
      to_pend = 0;
`endif
      #1;
      chk("async pause_cpu", pause_cpu, 1'b0);
      chk("async hs_grant", hs_grant, 1'b0);
      chk("async hs_ack", hs_ack, 1'b0);
      chk("async hs_dout", hs_dout, 8'h00);
      chk("async ram_we", ram_we, 1'b0);
      eval_cycle();
      advance();
      hs_strobe = 1'b0;
      hs_we = 1'b0;
      step();
      reset_n = 1'b1;
      repeat (6) step();
   endtask

   initial begin
      int k;
      for (int i = 0; i < 65536; i++) begin
         mem[i] = 8'h00;
         shadow[i] = 8'h00;
      end
      do_reset();

      // Handover latency from an idle CPU.
      hs_req = 1'b1;
      step();
      chk("pause at cycle 1", pause_cpu, 1'b1);
      wait_grant(k);
      chk("grant cycle", k + 1, 6);

      // Write then back-to-back read of the same byte.
      hs_addr = 16'h1234;
      hs_din = 8'hA5;
      hs_we = 1'b1;
      hs_strobe = 1'b1;
      step();
      hs_we = 1'b0;
      hs_din = 8'h00;
      step();
      hs_strobe = 1'b0;
      repeat (3) step();
      chk("hs_dout readback", hs_dout, 8'hA5);

      // Release: grant drops at once, pause two cycles later.
      hs_req = 1'b0;
      cpu_addr = 16'h0042;
      #1;
      chk("drop hs_grant", hs_grant, 1'b0);
      chk("drop ram_addr", ram_addr, 16'h0042);
      step();
      chk("drain pause", pause_cpu, 1'b1);
      step();
      chk("idle pause", pause_cpu, 1'b0);

      // CPU activity inside the guard window restarts the count.
      hs_req = 1'b1;
      repeat (3) step();
      cpu_mreq = 1'b1;
      step();
      cpu_mreq = 1'b0;
      wait_grant(k);
      chk("recount latency", k, GD + 1);

      // Async reset mid-grant; hs_req stays high across the release.
      reset_mid();
      wait_grant(k);
      chk("grant after reset", hs_grant, 1'b1);
      hs_req = 1'b0;
      repeat (3) step();

      for (int i = 0; i < 3000; i++) begin
         cpu_mreq = ($urandom_range(0, 9) < 3);
         cpu_we = cpu_mreq & 1'($urandom_range(0, 1));
         cpu_addr = 16'h1230 + 16'($urandom_range(0, 7));
         cpu_din = 8'($urandom);
         if ($urandom_range(0, 39) == 0) hs_req = ~hs_req;
         hs_strobe = ($urandom_range(0, 2) == 0);
         hs_we = 1'($urandom_range(0, 1));
         hs_addr = 16'h1230 + 16'($urandom_range(0, 7));
         hs_din = 8'($urandom);
         step();
      end
      cpu_mreq = 1'b0;
      cpu_we = 1'b0;
      hs_strobe = 1'b0;
      hs_req = 1'b0;
      repeat (4) step();

`ifdef HS_ARB_TIMEOUT_EN
      cpu_mreq = 1'b1;
      hs_req = 1'b1;
      k = 0;
      while (hs_timeout !== 1'b1 && k < 65600) begin
         step();
         k++;
      end
      chk("timeout latency", k, 65536);
      hs_req = 1'b0;
      step();
      chk("timeout to idle", pause_cpu, 1'b0);
      cpu_mreq = 1'b0;
      repeat (3) step();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hs_ram_arbiter.md
HS_RAM_ARBITER -- requirements
Module: hs_ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16: RAM address width.
REQ-002 Parameter GUARD, default 4: idle cycles required after the CPU goes quiet, before the hiscore engine is granted the port (1..15).
REQ-003 Port clk_sys  in  1: single clock for all logic.
REQ-004 Port reset_n  in  1: reset, asynchronous, active-low.
REQ-005 Port cpu_addr / cpu_din / cpu_we  in  ADDR_W/8/1: CPU RAM access.
REQ-006 Port cpu_mreq  in  1: CPU bus cycle in progress.
REQ-007 Port hs_req  in  1: hiscore engine requests exclusive RAM ownership; level signal.
REQ-008 Port hs_addr / hs_din / hs_we / hs_strobe  in  ADDR_W/8/1/1: hiscore access; the access is valid on hs_strobe.
REQ-009 Port ram_addr / ram_din / ram_we  out  ADDR_W/8/1: muxed single-port RAM drive.
REQ-010 Port ram_dout  in  8: RAM read data, 1-cycle read latency.
REQ-011 Port pause_cpu  out  1: CPU hold request.
REQ-012 Port hs_grant  out  1: hiscore owns the RAM.
REQ-013 Port hs_dout / hs_ack  out  8/1: hiscore read data and per-access completion pulse.

Function
REQ-014 The block SHALL have states IDLE, HOLD, GUARD, GRANT and DRAIN, encoded as a registered FSM.
REQ-015 IDLE: the RAM port SHALL follow cpu_* combinationally; on hs_req=1 the FSM SHALL move to HOLD and assert pause_cpu on the next cycle.
REQ-016 HOLD: the FSM SHALL wait for cpu_mreq=0, then load the guard counter with GUARD-1 and move to GUARD.
REQ-017 GUARD: the counter SHALL decrement each cycle while cpu_mreq=0; cpu_mreq=1 SHALL return the FSM to HOLD; reaching 0 SHALL move it to GRANT.
REQ-018 GRANT: hs_grant SHALL be 1 and ram_* SHALL follow hs_*; ram_we SHALL equal hs_we&hs_strobe.
REQ-019 In GRANT, hs_ack SHALL pulse exactly 1 cycle after each hs_strobe, with hs_dout registered from ram_dout in that same cycle; back-to-back strobes SHALL each be acknowledged.
REQ-020 In GRANT, hs_req=0 SHALL move the FSM to DRAIN; hs_grant SHALL drop in the same cycle as the transition.
REQ-021 DRAIN: the FSM SHALL hold for 1 cycle so any outstanding hs_ack completes, then deassert pause_cpu and return to IDLE.
REQ-022 An hs_strobe received outside GRANT SHALL be ignored: no RAM write and no hs_ack.
REQ-023 hs_req dropping in HOLD or GUARD SHALL go directly to DRAIN without granting.
REQ-024 pause_cpu SHALL be 1 in HOLD, GUARD, GRANT and DRAIN, and 0 only in IDLE.
REQ-025 cpu_we SHALL never reach ram_we while hs_grant=1.

Reset
REQ-026 While reset_n=0: state IDLE; pause_cpu, hs_grant, hs_ack = 0; hs_dout = 0x00; guard counter = 0.
REQ-027 Reset asserted mid-GRANT SHALL immediately release the port to the CPU with no spurious ram_we.
REQ-028 Release of reset SHALL be synchronized internally (2-flop) before the FSM leaves IDLE.

Configuration
REQ-029 Macro HS_ARB_TIMEOUT_EN SHALL compile in a 16-bit watchdog: if HOLD+GUARD lasts 65535 cycles, the FSM SHALL move to DRAIN and pulse an extra output port, hs_timeout, for 1 cycle.
REQ-030 Without HS_ARB_TIMEOUT_EN: no watchdog is built, HOLD waits indefinitely, and the hs_timeout port does not exist.

Verification
REQ-031 Scenario: cpu_mreq=0, hs_req rises at cycle 0, GUARD=4 -> pause_cpu=1 at cycle 1; hs_grant=1 at cycle 6.
REQ-032 Scenario: in GRANT, strobe write 0xA5 to 0x1234, then strobe read of 0x1234 -> ram_we pulses once; hs_ack pulses 1 cycle after each strobe; hs_dout=0xA5.
REQ-033 Scenario: cpu_mreq toggles 1 during GUARD count 2 -> FSM returns to HOLD and the full GUARD is re-counted after idle.
REQ-034 Scenario: hs_req drops in GRANT -> hs_grant=0 the same cycle; pause_cpu=0 two cycles later; ram_* follows cpu_*.
REQ-035 Scenario: reset_n pulsed low mid-GRANT with hs_we=1 -> all outputs 0 asynchronously; no ram_we from the hiscore side.
REQ-036 Scenario: HS_ARB_TIMEOUT_EN defined, cpu_mreq stuck at 1 -> hs_timeout pulses after 65535 cycles; FSM passes through DRAIN to IDLE.
